// File: rtl/sync_to_oneof2_tx.sv
// Clocked-to-async transmitter: serialises valid/ready words LSB first as 1-of-2 PCHB tokens on R.
// Optional macro PARITY_TOKEN_EN appends an even-parity token after the W data tokens.
module sync_to_oneof2_tx #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [1:0]   R,
  input  logic         Re,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         err_clr
);

`ifdef PARITY_TOKEN_EN
  localparam int TOKENS = W + 1;
`else
  localparam int TOKENS = W;
`endif
  localparam int CW  = (TOKENS > 1) ? $clog2(TOKENS) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TOKENS - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_EN, DATA} state_t;

  state_t              state_reg;
  logic [TOKENS-1:0]   shreg_reg;
  logic [CW-1:0]       cnt_reg;
  logic [WDW-1:0]      wd_reg;
  logic                re_meta_reg;
  logic                en_s_reg;
  logic [1:0]          r_reg;
  logic                done_reg;
  logic                err_reg;
  logic [TOKENS-1:0]   load_word;
  logic                progress;
  logic                wd_hit;

`ifdef PARITY_TOKEN_EN
  assign load_word = {^in_data, in_data};
`else
  assign load_word = in_data;
`endif

  // A state is "making progress" when its handshake condition fires this cycle;
  // the watchdog only trips when it does not.
  always_comb begin
    progress = 1'b0;
    wd_hit   = 1'b0;
    case (state_reg)
      WAIT_EN: progress = en_s_reg;
      DATA:    progress = ~en_s_reg;
      default: progress = 1'b0;
    endcase
    if ((TIMEOUT > 0) && (state_reg != IDLE) && !progress && (wd_reg == WD_LAST))
      wd_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      wd_reg      <= '0;
      re_meta_reg <= 1'b0;
      en_s_reg    <= 1'b0;
      r_reg       <= 2'b00;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      re_meta_reg <= Re;
      en_s_reg    <= re_meta_reg;
      done_reg    <= 1'b0;
      if (err_clr)
        err_reg <= 1'b0;

      if (wd_hit) begin
        // Set wins over a simultaneous clear; the in-flight word is dropped.
        err_reg   <= 1'b1;
        r_reg     <= 2'b00;
        state_reg <= IDLE;
        wd_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            wd_reg <= '0;
            if (in_valid) begin
              shreg_reg <= load_word;
              cnt_reg   <= '0;
              state_reg <= WAIT_EN;
            end
          end
          WAIT_EN: begin
            if (en_s_reg) begin
              r_reg     <= shreg_reg[0] ? 2'b10 : 2'b01;
              state_reg <= DATA;
              wd_reg    <= '0;
            end else begin
              wd_reg <= wd_reg + 1'b1;
            end
          end
          DATA: begin
            if (!en_s_reg) begin
              r_reg     <= 2'b00;
              shreg_reg <= shreg_reg >> 1;
              cnt_reg   <= cnt_reg + 1'b1;
              wd_reg    <= '0;
              if (cnt_reg == CNT_LAST) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= WAIT_EN;
              end
            end else begin
              wd_reg <= wd_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign in_ready = (state_reg == IDLE) && !reset;
  assign busy     = (state_reg != IDLE);
  assign R        = r_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_sync_to_oneof2_tx.sv
// Directed/table-driven bench for sync_to_oneof2_tx with a PCHB receiver model on R/Re.
// Honours PARITY_TOKEN_EN the same way as the design.
module tb_sync_to_oneof2_tx;

`ifdef PARITY_TOKEN_EN
  localparam int NTOK = 9;
`else
  localparam int NTOK = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] R;
  logic       Re;
  logic       busy;
  logic       done;
  logic       err;
  logic       err_clr;

  sync_to_oneof2_tx #(.W(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .R(R), .Re(Re), .busy(busy), .done(done),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   bad_r  = 0;
  logic rx_on  = 1'b0;
  int   rx_min = 0;
  int   rx_max = 3;
  logic tokq[$];
  logic [1:0] r_prev = 2'b00;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_word;
    logic       exp_par;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] tok_word(input int off);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < 8; i++)
      if (off + i < tokq.size()) w[i] = tokq[off + i];
    return w;
  endfunction

  // R must never be 11 and must pass through neutral between tokens.
  always @(negedge clk) begin
    if (R == 2'b11) bad_r++;
    if (r_prev != 2'b00 && R != 2'b00 && R != r_prev) bad_r++;
    r_prev = R;
  end

  // Four-phase receiver: capture token, lower Re; after neutral, raise Re.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_on) begin
        if (Re && R != 2'b00) begin
          tokq.push_back(R[1]);
          repeat ($urandom_range(rx_max, rx_min)) @(negedge clk);
          Re = 1'b0;
        end else if (!Re && R == 2'b00) begin
          repeat ($urandom_range(rx_max, rx_min)) @(negedge clk);
          Re = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 4000) begin @(negedge clk); n++; end
    if (!in_ready) check("send in_ready timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    check($sformatf("%s done", nm), done, 1);
    check($sformatf("%s busy@done", nm), busy, 0);
    @(negedge clk);
    check($sformatf("%s done width", nm), done, 0);
  endtask

  task automatic wait_rx_idle();
    int n = 0;
    while (Re !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("rx returns Re=1", Re, 1);
  endtask

  task automatic check_word(input string nm, input int off, input logic [7:0] w, input logic p);
    check($sformatf("%s word", nm), tok_word(off), w);
`ifdef PARITY_TOKEN_EN
    if (off + 8 < tokq.size()) check($sformatf("%s parity", nm), tokq[off + 8], p);
    else check($sformatf("%s parity missing", nm), 0, 1);
`else
    check($sformatf("%s unused parity arg", nm), p, p ^ 1'b0);
`endif
  endtask

  initial begin
    int n;
    logic saw_done;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h07, 8'h07, 1'b1};
    vecs[2] = '{8'h01, 8'h01, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 8'h3C, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b1};
    vecs[7] = '{8'h7E, 8'h7E, 1'b0};
    vecs[8] = '{8'h55, 8'h55, 1'b0};

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; err_clr = 1'b0; Re = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset R", R, 2'b00);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1);
    @(negedge clk);
    rx_on = 1'b1;

    // Table: T1 (A5) and T5 (07) plus further patterns, fast receiver.
    for (int i = 0; i < 9; i++) begin
      tokq.delete();
      send(vecs[i].data);
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d token count", i), tokq.size(), NTOK);
      check_word($sformatf("vec%0d", i), 0, vecs[i].exp_word, vecs[i].exp_par);
      $display("vec %0d: data=%02h tokens=%0d word=%02h", i, vecs[i].data, tokq.size(), tok_word(0));
      wait_rx_idle();
    end

    // T3: back-to-back with in_valid held.
    tokq.delete();
    in_data = 8'h01; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_data = 8'hFF;
    check("b2b ready while busy", in_ready, 0);
    n = 0;
    while (done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    check("b2b first done", done, 1);
    check("b2b in_ready in done cycle", in_ready, 1);
    check("b2b first count", tokq.size(), NTOK);
    @(negedge clk);
    check("b2b second accepted", busy, 1);
    in_valid = 1'b0;
    wait_done("b2b second");
    check("b2b total count", tokq.size(), 2 * NTOK);
    check_word("b2b w0", 0, 8'h01, 1'b1);
    check_word("b2b w1", NTOK, 8'hFF, 1'b0);
    $display("b2b: words %02h %02h", tok_word(0), tok_word(NTOK));
    wait_rx_idle();

    // T2: receiver never acknowledges -> watchdog.
    rx_on = 1'b0; Re = 1'b1;
    send(8'hC3);
    n = 0;
    while (R == 2'b00 && n < 100) begin @(negedge clk); n++; end
    check("wd first token on R", R != 2'b00, 1);
    n = 0; saw_done = 1'b0;
    while (!err && n < 200) begin @(negedge clk); n++; if (done) saw_done = 1'b1; end
    check("wd cycles to err", n, 64);
    check("wd R neutral", R, 2'b00);
    check("wd in_ready", in_ready, 1);
    check("wd busy", busy, 0);
    check("wd no done", saw_done, 0);
    $display("watchdog: err after %0d cycles", n);
    rx_on = 1'b1;
    tokq.delete();
    send(8'h5A);
    wait_done("err no block");
    check("err no block count", tokq.size(), NTOK);
    check_word("err no block", 0, 8'h5A, 1'b0);
    check("err sticky", err, 1);
    wait_rx_idle();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err cleared", err, 0);

    // Timeout with err_clr held: set wins.
    rx_on = 1'b0; Re = 1'b1; err_clr = 1'b1;
    send(8'h81);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("set wins err", err, 1);
    @(negedge clk);
    check("clr after set", err, 0);
    err_clr = 1'b0;
    $display("set-vs-clear: err observed then cleared");
    rx_on = 1'b1;

    // T4: reset while the 4th token of 3C is on R.
    rx_min = 1; rx_max = 5;
    tokq.delete();
    send(8'h3C);
    n = 0;
    while (tokq.size() < 4 && n < 2000) begin @(negedge clk); n++; end
    check("rst 4th token seen", tokq.size(), 4);
    check("rst 4th token value", tokq[3], 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst mid R", R, 2'b00);
    check("rst mid busy", busy, 0);
    check("rst mid done", done, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    wait_rx_idle();
    repeat (4) @(negedge clk);
    tokq.delete();
    send(8'h00);
    wait_done("post-rst");
    check("post-rst count", tokq.size(), NTOK);
    check_word("post-rst", 0, 8'h00, 1'b0);
    $display("reset mid-word: follow-up word=%02h", tok_word(0));
    wait_rx_idle();

    // T6: random receiver delays, random words.
    rx_min = 1; rx_max = 20;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      tokq.delete();
      send(d);
      wait_done($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d count", i), tokq.size(), NTOK);
      check_word($sformatf("rnd%0d", i), 0, d, ^d);
      $display("rnd %0d: sent=%02h got=%02h", i, d, tok_word(0));
      wait_rx_idle();
    end

    check("R legal and RTZ", bad_r, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
